// File: rtl/mem_arb.sv
// Two-port arbiter (A: fetch, B: load/store) in front of one single-port synchronous memory.
// Round-robin on conflict; a read response is held until its owner asserts rready.
module mem_arb #(
  parameter bit PRIO_B_FIRST = 1'b0,
  parameter int HBIT_ADDR    = 9,
  parameter int HBIT_DATA    = 23
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_a_req,
  input  logic [HBIT_ADDR:0] iw_a_addr,
  output logic               ow_a_gnt,
  output logic               ow_a_rvalid,
  input  logic               iw_a_rready,
  input  logic               iw_b_req,
  input  logic               iw_b_we,
  input  logic [HBIT_ADDR:0] iw_b_addr,
  input  logic [HBIT_DATA:0] iw_b_wdata,
  output logic               ow_b_gnt,
  output logic               ow_b_rvalid,
  input  logic               iw_b_rready,
  output logic [HBIT_DATA:0] ow_rdata,
  output logic               ow_mem_we,
  output logic [HBIT_ADDR:0] ow_mem_addr,
  output logic [HBIT_DATA:0] ow_mem_wdata,
  input  logic [HBIT_DATA:0] iw_mem_rdata
);

  // Handshake: a request is accepted only in a cycle where its gnt=1. A response
  // is offered while rvalid=1 and consumed in the cycle where rvalid=1 and rready=1;
  // rvalid depends only on registered state, never on same-cycle rready.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e             state_q;
  logic               owner_b_q;
  logic               last_b_q;
  logic [HBIT_DATA:0] hold_q;

  logic owner_rready;
  logic can_issue;
  logic a_wins;
  logic gnt_a;
  logic gnt_b;
  logic rd_gnt;

  always_comb begin
    owner_rready = owner_b_q ? iw_b_rready : iw_a_rready;
    // Reset is folded in so grants and the write strobe drop the instant reset asserts.
    can_issue    = iw_rst_n && ((state_q == IDLE) || owner_rready);
    a_wins       = !iw_b_req || last_b_q;
    gnt_a        = can_issue && iw_a_req && a_wins;
    gnt_b        = can_issue && iw_b_req && !(iw_a_req && a_wins);
    rd_gnt       = gnt_a || (gnt_b && !iw_b_we);
  end

  assign ow_a_gnt     = gnt_a;
  assign ow_b_gnt     = gnt_b;
  assign ow_mem_we    = gnt_b && iw_b_we;
  assign ow_mem_addr  = gnt_b ? iw_b_addr : iw_a_addr;
  assign ow_mem_wdata = iw_b_wdata;

  assign ow_a_rvalid  = (state_q != IDLE) && !owner_b_q;
  assign ow_b_rvalid  = (state_q != IDLE) &&  owner_b_q;
  assign ow_rdata     = (state_q == RESP) ? iw_mem_rdata : hold_q;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q   <= IDLE;
      owner_b_q <= 1'b0;
      // last_b_q=1 means B was granted last, so A wins the next conflict.
      last_b_q  <= !PRIO_B_FIRST;
      hold_q    <= '0;
    end else begin
      if (gnt_a || gnt_b) begin
        last_b_q <= gnt_b;
      end
      if (rd_gnt) begin
        state_q   <= RESP;
        owner_b_q <= gnt_b;
      end else if ((state_q != IDLE) && !owner_rready) begin
        state_q <= HOLD;
        if (state_q == RESP) begin
          hold_q <= iw_mem_rdata;
        end
      end else begin
        state_q <= IDLE;
      end
    end
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter SHALL be: PRIO_B_FIRST, default 0, port B wins the first conflict after reset when 1, else port A wins.
REQ-003 Ports SHALL be (name direction width meaning):
- iw_clk  in  1  clock
- iw_rst_n  in  1  async active-low reset
- iw_a_req  in  1  port A (fetch, read-only) request
- iw_a_addr  in  HBIT_ADDR+1  port A address
- ow_a_gnt  out  1  port A request accepted this cycle
- ow_a_rvalid  out  1  read data valid for port A
- iw_a_rready  in  1  port A consumes response
- iw_b_req  in  1  port B (load/store) request
- iw_b_we  in  1  port B write enable (1 = write)
- iw_b_addr  in  HBIT_ADDR+1  port B address
- iw_b_wdata  in  HBIT_DATA+1  port B write data
- ow_b_gnt  out  1  port B request accepted this cycle
- ow_b_rvalid  out  1  read data valid for port B
- iw_b_rready  in  1  port B consumes response
- ow_rdata  out  HBIT_DATA+1  shared read data, qualified by the rvalids
- ow_mem_we  out  1  memory write enable
- ow_mem_addr  out  HBIT_ADDR+1  memory address
- ow_mem_wdata  out  HBIT_DATA+1  memory write data
- iw_mem_rdata  in  HBIT_DATA+1  memory read data, one cycle after address

Function
REQ-004 The block SHALL share one single-port synchronous memory (1-cycle read latency, registered read data) between ports A and B.
REQ-005 The state machine SHALL have states IDLE, RESP (read issued last cycle, data on iw_mem_rdata), HOLD (response captured, awaiting rready).
REQ-006 Issue SHALL be allowed in IDLE, in RESP when the response owner's rready=1, and in HOLD when the owner's rready=1; otherwise both gnts SHALL be 0.
REQ-007 Grants SHALL be combinational from reqs and state; at most one gnt per cycle; a request is accepted only in a cycle where its gnt=1.
REQ-008 Single requester: that port SHALL be granted; both requesting: round-robin, granting the port not granted last; pointer SHALL update on every grant.
REQ-009 On grant, ow_mem_addr/ow_mem_wdata/ow_mem_we SHALL carry the granted port's addr/wdata/we (A always we=0); with no grant, ow_mem_we=0 and ow_mem_addr=iw_a_addr.
REQ-010 Granted read SHALL go to RESP next cycle, owner recorded; granted write SHALL produce no response and, absent a granted read, go to IDLE.
REQ-011 In RESP, ow_rdata SHALL equal iw_mem_rdata and the owner's rvalid=1; owner rready=0 SHALL capture iw_mem_rdata into a hold register and go to HOLD.
REQ-012 In HOLD, owner rvalid SHALL stay 1 and ow_rdata SHALL stay equal to the hold register, stable until rready=1.
REQ-013 Response consumed with no new read granted SHALL go to IDLE; with a new read granted SHALL go to RESP (back-to-back reads, one per cycle).
REQ-014 Never both rvalids at once; rvalid SHALL never depend on rready of the same cycle.
REQ-015 Write followed next cycle by a read of the same address SHALL return the written data (memory ordering, no forwarding needed).
REQ-016 Non-owner rready SHALL be ignored.

Reset
REQ-017 Reset assertion SHALL immediately force: state IDLE, both rvalids 0, both gnts 0, ow_mem_we 0, ow_rdata 0, hold register 0, pointer per PRIO_B_FIRST.
REQ-018 Reset mid-response SHALL discard the pending response; no rvalid SHALL appear for it after release.

Verification
REQ-019 A reads 0x010 (mem=0x123456), rready=1 -> a_gnt cycle 0; a_rvalid=1, ow_rdata=0x123456 cycle 1; IDLE cycle 2.
REQ-020 A and B both read continuously, PRIO_B_FIRST=0 -> grants A,B,A,B...; rvalids alternate one cycle behind.
REQ-021 B writes 0xABCDEF to 0x020, A reads 0x020 next cycle -> ow_mem_we=1 only in write cycle; A receives 0xABCDEF; no b_rvalid.
REQ-022 A read with a_rready=0 for 3 cycles -> a_rvalid held, ow_rdata stable, no gnts while B requests; a_rready=1 -> b_gnt that same cycle.
REQ-023 A reads 0x000..0x003 back-to-back, rready=1 -> four gnts on cycles 0-3, four responses on cycles 1-4, in order.
REQ-024 Reset asserted in RESP and in HOLD -> rvalid 0 asynchronously; after release IDLE, no stale response, first conflict won per PRIO_B_FIRST.
